cv32e40p_ft_fault_manager: RTL and testbench
============================================

CV32E40P_FT_FAULT_MANAGER -- requirements
Module: cv32e40p_ft_fault_manager

Interface
REQ-001 SHALL have parameter N_BLK, default 8: number of monitored fault-tolerant blocks.
REQ-002 SHALL have parameter CNT_W, default 16: width of each per-block corrected-error counter.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 8: maximum number of cycles to wait for broken-state acknowledge.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port err_detected_i, input, N_BLK: per-block voter error-detected flag.
REQ-007 SHALL have port err_corrected_i, input, N_BLK: per-block voter error-corrected flag.
REQ-008 SHALL have port is_broken_i, input, 3*N_BLK: per-block, per-replica breakage-monitor state (bits [3b+2:3b] belong to block b).
REQ-009 SHALL have port set_broken_o, output, 3*N_BLK: per-replica force-broken request to the breakage monitors.
REQ-010 SHALL have ports cmd_valid_i (input, 1), cmd_ready_o (output, 1), cmd_op_i (input, 2), cmd_blk_i (input, clog2(N_BLK)), cmd_rep_i (input, 2): command channel.
REQ-011 SHALL have ports resp_valid_o (output, 1), resp_ready_i (input, 1), resp_data_o (output, CNT_W), resp_err_o (output, 1): response channel.
REQ-012 SHALL have port fatal_o, output, 1: sticky unrecoverable-fault flag.

Function
REQ-013 SHALL implement FSM states IDLE, FORCE, WAIT_ACK, RESP.
- IDLE: cmd_ready_o=1; a command is accepted on cmd_valid_i&cmd_ready_o.
- After acceptance, cmd_ready_o=0 until the FSM returns to IDLE.
REQ-014 SHALL define cmd_op_i encodings: 0 READ_CNT, 1 CLEAR_CNT, 2 FORCE_BROKEN, 3 reserved.
- READ_CNT / CLEAR_CNT: IDLE->RESP.
- FORCE_BROKEN: IDLE->FORCE.
- Reserved op: IDLE->RESP with resp_err_o=1.
REQ-015 SHALL, on READ_CNT, return counter[cmd_blk_i] captured at acceptance on resp_data_o.
REQ-016 SHALL, on CLEAR_CNT, zero counter[cmd_blk_i] on the acceptance edge and return resp_data_o=0.
- An increment to that block in the same cycle is dropped.
REQ-017 SHALL, in FORCE, assert set_broken_o[3*blk+rep] for exactly one cycle, then enter WAIT_ACK.
REQ-018 SHALL stay in WAIT_ACK until is_broken_i[3*blk+rep]=1, then enter RESP with resp_err_o=0.
- If ACK_TIMEOUT cycles elapse without acknowledge, SHALL enter RESP with resp_err_o=1.
REQ-019 SHALL return resp_err_o=1 immediately (IDLE->RESP) when cmd_rep_i=3 or cmd_blk_i>=N_BLK.
REQ-020 SHALL hold resp_valid_o=1 in RESP with data stable, and return to IDLE on resp_valid_o&resp_ready_i.
REQ-021 SHALL count, per block, each cycle with err_corrected_i[b]=1.
- Counter saturates at 2^CNT_W-1; it does not wrap.
REQ-022 SHALL set fatal_o on the edge following any of:
- err_detected_i[b]&~err_corrected_i[b] for any block b;
- two or more replicas of any block showing is_broken_i=1.
REQ-023 SHALL keep fatal_o set until reset; commands continue to be served while it is set.
REQ-024 SHALL drive set_broken_o to 0 in every state except FORCE.

Reset
REQ-025 SHALL, on rst_n=0 (asynchronous, any state, mid-command), force:
- FSM to IDLE;
- all counters, the timeout counter, set_broken_o, resp_valid_o, resp_data_o, resp_err_o and fatal_o to 0;
- cmd_ready_o to 1 after reset release.

Configuration
REQ-026 SHALL compile the per-block counters only when macro CV32E40P_FT_ERR_COUNTERS_EN is defined.
- Without the macro: no counter storage; READ_CNT returns 0 with resp_err_o=1; CLEAR_CNT returns resp_err_o=1.
- FORCE_BROKEN and fatal_o behaviour is identical with and without the macro.

Structure
REQ-027 SHALL take the command-op enum and the FSM state typedef from the shared package cv32e40p_pkg2_ft, together with the FTFM_N_BLK/FTFM_CNT_W defaults.
REQ-028 SHALL instantiate the sub-module cv32e40p_ft_err_counter (saturating counter with clear) once per block, generated under the macro.

Verification
REQ-029 SHALL cover: err_corrected_i[2]=1 for 5 cycles, then READ_CNT blk 2 -> resp_data_o=5, resp_err_o=0.
REQ-030 SHALL cover: CNT_W=4 with 20 corrected cycles on blk 0, then READ_CNT -> resp_data_o=15 (saturated).
REQ-031 SHALL cover: FORCE_BROKEN blk 1 rep 2 with the monitor acknowledging 3 cycles later -> set_broken_o[5] high for exactly 1 cycle, then resp_err_o=0.
REQ-032 SHALL cover: FORCE_BROKEN with no acknowledge -> resp_valid_o after ACK_TIMEOUT=8 cycles with resp_err_o=1.
REQ-033 SHALL cover: err_detected_i[3]=1 with err_corrected_i[3]=0 for 1 cycle -> fatal_o=1 next cycle and held until rst_n=0.
REQ-034 SHALL cover: rst_n asserted during WAIT_ACK with resp_ready_i=0 -> all outputs 0 immediately, cmd_ready_o=1 after release.

Source files
------------

// File: rtl/cv32e40p_pkg2_ft.sv
// ============================================================================
// cv32e40p_pkg2_ft : shared types and defaults for the FT fault manager
// Revision: 1.0
// ============================================================================
`default_nettype none

package cv32e40p_pkg2_ft;

   localparam int FTFM_N_BLK = 8;
   localparam int FTFM_CNT_W = 16;

   typedef enum logic [1:0] {
      READ_CNT     = 2'd0,
      CLEAR_CNT    = 2'd1,
      FORCE_BROKEN = 2'd2,
      OP_RSVD      = 2'd3
   } ftfm_op_e;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FORCE    = 2'd1,
      WAIT_ACK = 2'd2,
      RESP     = 2'd3
   } ftfm_state_e;

   // Majority-style test: true when at least two of the three replicas are set.
   function automatic logic two_of_three(input logic [2:0] t);
      return (t[0] & t[1]) | (t[0] & t[2]) | (t[1] & t[2]);
   endfunction

endpackage

`default_nettype wire

// File: rtl/cv32e40p_ft_err_counter.sv
// ============================================================================
// cv32e40p_ft_err_counter : saturating corrected-error counter with clear
// Revision: 1.0
// ============================================================================
`default_nettype none

module cv32e40p_ft_err_counter
   import cv32e40p_pkg2_ft::*;
#(
   parameter int CNT_W = FTFM_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q;

   // Clear wins over a same-cycle increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/cv32e40p_ft_fault_manager.sv
// ============================================================================
// cv32e40p_ft_fault_manager : error counting, force-broken commands, fatal flag
// Optional counters: define CV32E40P_FT_ERR_COUNTERS_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module cv32e40p_ft_fault_manager
   import cv32e40p_pkg2_ft::*;
#(
   parameter int N_BLK       = FTFM_N_BLK,
   parameter int CNT_W       = FTFM_CNT_W,
   parameter int ACK_TIMEOUT = 8
) (
   input  logic                                        clk,
   input  logic                                        rst_n,
   input  logic [N_BLK-1:0]                            err_detected_i,
   input  logic [N_BLK-1:0]                            err_corrected_i,
   input  logic [3*N_BLK-1:0]                          is_broken_i,
   output logic [3*N_BLK-1:0]                          set_broken_o,
   input  logic                                        cmd_valid_i,
   output logic                                        cmd_ready_o,
   input  logic [1:0]                                  cmd_op_i,
   input  logic [((N_BLK > 1) ? $clog2(N_BLK) : 1)-1:0] cmd_blk_i,
   input  logic [1:0]                                  cmd_rep_i,
   output logic                                        resp_valid_o,
   input  logic                                        resp_ready_i,
   output logic [CNT_W-1:0]                            resp_data_o,
   output logic                                        resp_err_o,
   output logic                                        fatal_o
);

   localparam int BLK_W = (N_BLK > 1) ? $clog2(N_BLK) : 1;
   localparam int NR    = 3 * N_BLK;
   localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);

   ftfm_state_e      state_q, state_d;
   logic [BLK_W-1:0] blk_q, blk_d;
   logic [1:0]       rep_q, rep_d;
   logic [TO_W-1:0]  timer_q, timer_d;
   logic [CNT_W-1:0] resp_data_q, resp_data_d;
   logic             resp_err_q, resp_err_d;
   logic             fatal_q;
   logic             fatal_evt;
   logic [NR-1:0]    sel_onehot;
   logic             ack;

   assign sel_onehot = NR'(1) << (3 * int'(blk_q) + int'(rep_q));
   assign ack        = |(is_broken_i & sel_onehot);

`ifdef CV32E40P_FT_ERR_COUNTERS_EN
   logic [N_BLK-1:0][CNT_W-1:0] cnt;
   logic [CNT_W-1:0]            rd_cnt;
   logic                        clr_req;

   for (genvar b = 0; b < N_BLK; b++) begin : g_cnt
      cv32e40p_ft_err_counter #(
         .CNT_W (CNT_W)
      ) u_cnt (
         .clk   (clk),
         .rst_n (rst_n),
         .inc_i (err_corrected_i[b]),
         .clr_i (clr_req && (int'(cmd_blk_i) == b)),
         .cnt_o (cnt[b])
      );
   end

   always_comb begin
      rd_cnt = '0;
      for (int b = 0; b < N_BLK; b++) begin
         if (int'(cmd_blk_i) == b) rd_cnt = cnt[b];
      end
   end
`endif

   always_comb begin
      fatal_evt = 1'b0;
      for (int b = 0; b < N_BLK; b++) begin
         if (err_detected_i[b] && !err_corrected_i[b]) fatal_evt = 1'b1;
         if (two_of_three(is_broken_i[3*b +: 3]))      fatal_evt = 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      blk_d       = blk_q;
      rep_d       = rep_q;
      timer_d     = timer_q;
      resp_data_d = resp_data_q;
      resp_err_d  = resp_err_q;
`ifdef CV32E40P_FT_ERR_COUNTERS_EN
      clr_req     = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (cmd_valid_i) begin
               // Every accepted command defaults to an error response; valid ones override.
               blk_d       = cmd_blk_i;
               rep_d       = cmd_rep_i;
               timer_d     = '0;
               resp_data_d = '0;
               resp_err_d  = 1'b1;
               state_d     = RESP;
               if ((int'(cmd_blk_i) < N_BLK) && (cmd_rep_i != 2'd3)) begin
                  case (ftfm_op_e'(cmd_op_i))
                     READ_CNT: begin
`ifdef CV32E40P_FT_ERR_COUNTERS_EN
                        resp_data_d = rd_cnt;
                        resp_err_d  = 1'b0;
`endif
                     end
                     CLEAR_CNT: begin
`ifdef CV32E40P_FT_ERR_COUNTERS_EN
                        clr_req     = 1'b1;
                        resp_err_d  = 1'b0;
`endif
                     end
                     FORCE_BROKEN: state_d = FORCE;
                     default: ;
                  endcase
               end
            end
         end
         FORCE: state_d = WAIT_ACK;
         WAIT_ACK: begin
            if (ack) begin
               state_d    = RESP;
               resp_err_d = 1'b0;
            end else if (timer_q == TO_W'(ACK_TIMEOUT - 1)) begin
               state_d    = RESP;
               resp_err_d = 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         RESP: begin
            if (resp_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         blk_q       <= '0;
         rep_q       <= '0;
         timer_q     <= '0;
         resp_data_q <= '0;
         resp_err_q  <= 1'b0;
         fatal_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         blk_q       <= blk_d;
         rep_q       <= rep_d;
         timer_q     <= timer_d;
         resp_data_q <= resp_data_d;
         resp_err_q  <= resp_err_d;
         fatal_q     <= fatal_q | fatal_evt;
      end
   end

   assign cmd_ready_o  = rst_n && (state_q == IDLE);
   assign resp_valid_o = (state_q == RESP);
   assign set_broken_o = (state_q == FORCE) ? sel_onehot : '0;
   assign resp_data_o  = resp_data_q;
   assign resp_err_o   = resp_err_q;
   assign fatal_o      = fatal_q;

endmodule

`default_nettype wire

// File: tb/tb_cv32e40p_ft_fault_manager.sv
// ============================================================================
// tb_cv32e40p_ft_fault_manager : self-checking bench with a behavioural model
// Counter expectations follow CV32E40P_FT_ERR_COUNTERS_EN when it is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cv32e40p_ft_fault_manager;

   localparam int NB   = 6;
   localparam int CW   = 4;
   localparam int TO   = 8;
   localparam int NR   = 3 * NB;
   localparam int BW   = 3;
   localparam int CMAX = (1 << CW) - 1;
`ifdef CV32E40P_FT_ERR_COUNTERS_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NB-1:0] err_detected_i, err_corrected_i;
   logic [NR-1:0] is_broken_i, set_broken_o;
   logic          cmd_valid_i, cmd_ready_o;
   logic [1:0]    cmd_op_i, cmd_rep_i;
   logic [BW-1:0] cmd_blk_i;
   logic          resp_valid_o, resp_ready_i, resp_err_o, fatal_o;
   logic [CW-1:0] resp_data_o;

   int cnt_m [NB];
   bit fatal_m;
   int clr_blk_m;
   bit bg_en;
   int n_chk, n_fail;

   cv32e40p_ft_fault_manager #(
      .N_BLK       (NB),
      .CNT_W       (CW),
      .ACK_TIMEOUT (TO)
   ) u_dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .err_detected_i  (err_detected_i),
      .err_corrected_i (err_corrected_i),
      .is_broken_i     (is_broken_i),
      .set_broken_o    (set_broken_o),
      .cmd_valid_i     (cmd_valid_i),
      .cmd_ready_o     (cmd_ready_o),
      .cmd_op_i        (cmd_op_i),
      .cmd_blk_i       (cmd_blk_i),
      .cmd_rep_i       (cmd_rep_i),
      .resp_valid_o    (resp_valid_o),
      .resp_ready_i    (resp_ready_i),
      .resp_data_o     (resp_data_o),
      .resp_err_o      (resp_err_o),
      .fatal_o         (fatal_o)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // One clock: update the reference model from the inputs seen at the edge.
   task automatic tick();
      int ones;
      @(posedge clk);
      if (rst_n) begin
         for (int b = 0; b < NB; b++) begin
            if (b == clr_blk_m)                          cnt_m[b] = 0;
            else if (err_corrected_i[b] && cnt_m[b] < CMAX) cnt_m[b] = cnt_m[b] + 1;
            if (err_detected_i[b] && !err_corrected_i[b]) fatal_m = 1'b1;
            ones = int'(is_broken_i[3*b]) + int'(is_broken_i[3*b+1]) + int'(is_broken_i[3*b+2]);
            if (ones >= 2) fatal_m = 1'b1;
         end
      end
      clr_blk_m = -1;
      #1;
      if (bg_en) begin
         err_corrected_i = NB'($urandom);
         err_detected_i  = NB'($urandom) & err_corrected_i;
      end
   endtask

   task automatic model_reset();
      for (int b = 0; b < NB; b++) cnt_m[b] = 0;
      fatal_m   = 1'b0;
      clr_blk_m = -1;
   endtask

   task automatic do_cmd(input int op, input int blk, input int rep, input int ack_dly,
                         input string name);
      int            exp_data, n, exp_n, hold;
      bit            exp_err, force_path;
      logic [NR-1:0] exp_sb;
      force_path = 1'b0;
      exp_data   = 0;
      exp_err    = 1'b1;
      if (blk < NB && rep != 3) begin
         case (op)
            0: if (CNT_EN) begin exp_data = cnt_m[blk]; exp_err = 1'b0; end
            1: if (CNT_EN) begin exp_err = 1'b0; clr_blk_m = blk; end
            2: force_path = 1'b1;
            default: ;
         endcase
      end
      n_chk++;
      if (cmd_ready_o !== 1'b1) begin
         n_fail++; $display("FAIL %s ready_before: got %b want 1", name, cmd_ready_o);
      end
      cmd_valid_i = 1'b1;
      cmd_op_i    = 2'(op);
      cmd_blk_i   = BW'(blk);
      cmd_rep_i   = 2'(rep);
      tick();
      cmd_valid_i = 1'b0;
      cmd_op_i    = 2'($urandom);
      cmd_blk_i   = BW'($urandom);
      n_chk++;
      if (cmd_ready_o !== 1'b0) begin
         n_fail++; $display("FAIL %s ready_busy: got %b want 0", name, cmd_ready_o);
      end
      if (force_path) begin
         exp_sb = NR'(1) << (3 * blk + rep);
         n_chk++;
         if (set_broken_o !== exp_sb || resp_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL %s force_pulse: got %h/%b want %h/0", name, set_broken_o, resp_valid_o, exp_sb);
         end
         tick();
         n_chk++;
         if (set_broken_o !== '0) begin
            n_fail++; $display("FAIL %s force_one_cycle: got %h want 0", name, set_broken_o);
         end
         n = 0;
         while (resp_valid_o !== 1'b1 && n < 40) begin
            if (n == ack_dly) is_broken_i[3*blk+rep] = 1'b1;
            tick();
            n++;
            if (set_broken_o !== '0) begin
               n_chk++; n_fail++;
               $display("FAIL %s set_broken_wait: got %h want 0", name, set_broken_o);
            end
         end
         exp_err = !(ack_dly >= 0 && ack_dly < TO);
         exp_n   = exp_err ? TO : ack_dly + 1;
         n_chk++;
         if (n != exp_n) begin
            n_fail++; $display("FAIL %s wait_cycles: got %0d want %0d", name, n, exp_n);
         end
      end
      n_chk++;
      if (resp_valid_o !== 1'b1 || resp_data_o !== CW'(exp_data) || resp_err_o !== exp_err) begin
         n_fail++;
         $display("FAIL %s resp: got v=%b d=%0d e=%b want v=1 d=%0d e=%b",
                  name, resp_valid_o, resp_data_o, resp_err_o, exp_data, exp_err);
      end
      hold = $urandom_range(0, 2);
      repeat (hold) begin
         tick();
         n_chk++;
         if (resp_valid_o !== 1'b1 || resp_data_o !== CW'(exp_data) || resp_err_o !== exp_err) begin
            n_fail++;
            $display("FAIL %s resp_hold: got v=%b d=%0d e=%b want v=1 d=%0d e=%b",
                     name, resp_valid_o, resp_data_o, resp_err_o, exp_data, exp_err);
         end
      end
      resp_ready_i = 1'b1;
      tick();
      resp_ready_i = 1'b0;
      is_broken_i  = '0;
      n_chk++;
      if (resp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
         n_fail++; $display("FAIL %s handshake: got v=%b r=%b want v=0 r=1", name, resp_valid_o, cmd_ready_o);
      end
      n_chk++;
      if (fatal_o !== fatal_m) begin
         n_fail++; $display("FAIL %s fatal: got %b want %b", name, fatal_o, fatal_m);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_chk++;
      if (set_broken_o !== '0 || resp_valid_o !== 1'b0 || resp_data_o !== '0 ||
          resp_err_o !== 1'b0 || fatal_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got sb=%h v=%b d=%0d e=%b f=%b want all 0",
                  set_broken_o, resp_valid_o, resp_data_o, resp_err_o, fatal_o);
      end
      rst_n = 1'b1;
      model_reset();
      #1;
      n_chk++;
      if (cmd_ready_o !== 1'b1) begin
         n_fail++; $display("FAIL reset_ready: got %b want 1", cmd_ready_o);
      end
      for (int b = 0; b < NB; b++) do_cmd(0, b, 0, 0, "reset_read");
   endtask

   task automatic test_count_read();
      err_corrected_i = NB'(1) << 2;
      repeat (5) tick();
      err_corrected_i = '0;
      if (CNT_EN) begin
         n_chk++;
         if (cnt_m[2] != 5) begin
            n_fail++; $display("FAIL count_model: got %0d want 5", cnt_m[2]);
         end
      end
      do_cmd(0, 2, 0, 0, "count_read_blk2");
   endtask

   task automatic test_saturation();
      err_corrected_i = NB'(1);
      repeat (20) tick();
      err_corrected_i = '0;
      do_cmd(0, 0, 1, 0, "saturate_blk0");
   endtask

   task automatic test_clear();
      err_corrected_i = NB'(1) << 2;
      do_cmd(1, 2, 0, 0, "clear_blk2");
      err_corrected_i = '0;
      do_cmd(0, 2, 0, 0, "read_after_clear");
      do_cmd(0, 0, 0, 0, "other_blk_kept");
   endtask

   task automatic test_force();
      do_cmd(2, 1, 2, 2, "force_ack");
      do_cmd(2, 4, 0, 0, "force_ack_fast");
      do_cmd(2, 3, 1, TO - 1, "force_ack_last");
      do_cmd(2, 0, 0, -1, "force_timeout");
   endtask

   task automatic test_errors();
      do_cmd(2, 2, 3, 0, "bad_rep");
      do_cmd(0, 6, 0, 0, "bad_blk6");
      do_cmd(1, 7, 1, 0, "bad_blk7");
      do_cmd(3, 1, 0, 0, "reserved_op");
   endtask

   task automatic test_random();
      bg_en = 1'b1;
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 3)) tick();
         do_cmd($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 3),
                $urandom_range(0, 10), "random");
      end
      bg_en           = 1'b0;
      err_corrected_i = '0;
      err_detected_i  = '0;
      for (int b = 0; b < NB; b++) do_cmd(0, b, 0, 0, "random_final_read");
   endtask

   task automatic test_fatal();
      n_chk++;
      if (fatal_o !== 1'b0) begin
         n_fail++; $display("FAIL fatal_pre: got %b want 0", fatal_o);
      end
      err_detected_i = NB'(1) << 3;
      tick();
      err_detected_i = '0;
      n_chk++;
      if (fatal_o !== 1'b1 || fatal_m !== 1'b1) begin
         n_fail++; $display("FAIL fatal_set: got %b want 1", fatal_o);
      end
      repeat (4) tick();
      n_chk++;
      if (fatal_o !== 1'b1) begin
         n_fail++; $display("FAIL fatal_sticky: got %b want 1", fatal_o);
      end
      do_cmd(2, 5, 0, 1, "force_while_fatal");
   endtask

   task automatic test_reset_mid();
      cmd_valid_i = 1'b1;
      cmd_op_i    = 2'd2;
      cmd_blk_i   = 3'd1;
      cmd_rep_i   = 2'd0;
      tick();
      cmd_valid_i = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      n_chk++;
      if (set_broken_o !== '0 || resp_valid_o !== 1'b0 || resp_data_o !== '0 ||
          resp_err_o !== 1'b0 || fatal_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_outputs: got sb=%h v=%b d=%0d e=%b f=%b want all 0",
                  set_broken_o, resp_valid_o, resp_data_o, resp_err_o, fatal_o);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      #1;
      n_chk++;
      if (cmd_ready_o !== 1'b1) begin
         n_fail++; $display("FAIL reset_mid_ready: got %b want 1", cmd_ready_o);
      end
      do_cmd(0, 2, 0, 0, "read_after_reset_mid");
   endtask

   task automatic test_broken_pair();
      is_broken_i = (NR'(1) << 12) | (NR'(1) << 14);
      #1;
      n_chk++;
      if (fatal_o !== 1'b0) begin
         n_fail++; $display("FAIL broken_pair_pre: got %b want 0", fatal_o);
      end
      tick();
      is_broken_i = '0;
      n_chk++;
      if (fatal_o !== 1'b1 || fatal_m !== 1'b1) begin
         n_fail++; $display("FAIL broken_pair_fatal: got %b want 1", fatal_o);
      end
   endtask

   initial begin
      n_chk           = 0;
      n_fail          = 0;
      bg_en           = 1'b0;
      clr_blk_m       = -1;
      err_detected_i  = '0;
      err_corrected_i = '0;
      is_broken_i     = '0;
      cmd_valid_i     = 1'b0;
      cmd_op_i        = '0;
      cmd_blk_i       = '0;
      cmd_rep_i       = '0;
      resp_ready_i    = 1'b0;
      model_reset();
      test_reset();
      test_count_read();
      test_saturation();
      test_clear();
      test_force();
      test_errors();
      test_random();
      test_fatal();
      test_reset_mid();
      test_broken_pair();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
